// File: rtl/otp_ctrl_zeroize_chk_if.sv
// OTP macro read-response channel as seen by the zeroization checker.
interface otp_ctrl_zeroize_chk_if #(
  parameter int OtpWidth = 16
) ();
  logic                hw_valid_i;
  logic                hw_ready_o;
  logic [OtpWidth-1:0] hw_data_i;
  logic [2:0]          hw_err_i;

  modport master (output hw_valid_i, hw_data_i, hw_err_i, input hw_ready_o);
  modport slave  (input hw_valid_i, hw_data_i, hw_err_i, output hw_ready_o);
endinterface

// File: rtl/otp_ctrl_zeroize_chk.sv
// Assembles OTP words into scramble blocks, popcounts each block serially and
// reports whether every block in the requested range meets the zeroization bound.
module otp_ctrl_zeroize_chk #(
  parameter int OtpWidth     = 16,
  parameter int BlockWidth   = 64,
  parameter int ValidBound   = 58,
  parameter int BitsPerCycle = 8,
  parameter int CntWidth     = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [CntWidth-1:0] num_blocks_i,
  output logic                busy_o,
  otp_ctrl_zeroize_chk_if.slave hw,
  output logic                done_o,
  output logic                zeroized_o,
  output logic                err_o,
  output logic [CntWidth-1:0] fail_idx_o,
  output logic [6:0]          ones_cnt_o
);

  localparam int AccW       = 7;
  localparam int WordsPerBlk = BlockWidth / OtpWidth;
  localparam int SlicesPerBlk = BlockWidth / BitsPerCycle;
  localparam int WIdxW      = (WordsPerBlk > 1) ? $clog2(WordsPerBlk) : 1;
  localparam int SIdxW      = (SlicesPerBlk > 1) ? $clog2(SlicesPerBlk) : 1;
  localparam logic [WIdxW-1:0] LastWord  = WIdxW'(WordsPerBlk - 1);
  localparam logic [SIdxW-1:0] LastSlice = SIdxW'(SlicesPerBlk - 1);
  localparam logic [AccW-1:0]  Bound     = AccW'(ValidBound);

  localparam logic [2:0] NoError             = 3'd0;
  localparam logic [2:0] MacroEccCorrError   = 3'd2;
  localparam logic [2:0] MacroEccUncorrError = 3'd3;

  typedef enum logic [1:0] {IDLE, COLLECT, COUNT, DONE} state_e;

  function automatic logic [AccW-1:0] popcnt(input logic [BitsPerCycle-1:0] v);
    logic [AccW-1:0] pc;
    pc = '0;
    for (int i = 0; i < BitsPerCycle; i++) pc = pc + AccW'(v[i]);
    return pc;
  endfunction

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   num_q, num_d;
  logic [CntWidth-1:0]   idx_q, idx_d;
  logic [WIdxW-1:0]      word_q, word_d;
  logic [SIdxW-1:0]      slice_q, slice_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic                  zer_q, zer_d;
  logic                  err_q, err_d;
  logic [CntWidth-1:0]   fail_q, fail_d;
  logic [AccW-1:0]       ones_q, ones_d;
  logic [BlockWidth-1:0] block_q;
  logic                  ready;
  logic                  word_we;
  logic                  shift_en;
  logic                  err_ok;
  logic [AccW-1:0]       sum;

  assign err_ok = (hw.hw_err_i == NoError) || (hw.hw_err_i == MacroEccCorrError) ||
                  (hw.hw_err_i == MacroEccUncorrError);
  assign sum    = acc_q + popcnt(block_q[BitsPerCycle-1:0]);

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    idx_d    = idx_q;
    word_d   = word_q;
    slice_d  = slice_q;
    acc_d    = acc_q;
    zer_d    = zer_q;
    err_d    = err_q;
    fail_d   = fail_q;
    ones_d   = ones_q;
    ready    = 1'b0;
    word_we  = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          zer_d  = 1'b0;
          fail_d = '0;
          ones_d = '0;
          if (num_blocks_i != '0) begin
            num_d   = num_blocks_i;
            idx_d   = '0;
            word_d  = '0;
            err_d   = 1'b0;
            state_d = COLLECT;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      COLLECT: begin
        ready = 1'b1;
        if (hw.hw_valid_i) begin
          if (err_ok) begin
            word_we = 1'b1;
            if (word_q == LastWord) begin
              word_d  = '0;
              slice_d = '0;
              acc_d   = '0;
              state_d = COUNT;
            end else begin
              word_d = word_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            zer_d   = 1'b0;
            fail_d  = idx_q;
            state_d = DONE;
          end
        end
      end
      COUNT: begin
        shift_en = 1'b1;
        acc_d    = sum;
        if (slice_q == LastSlice) begin
          ones_d = sum;
          if (sum >= Bound) begin
            if (idx_q == num_q - 1'b1) begin
              zer_d   = 1'b1;
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              word_d  = '0;
              state_d = COLLECT;
            end
          end else begin
            zer_d   = 1'b0;
            fail_d  = idx_q;
            state_d = DONE;
          end
        end else begin
          slice_d = slice_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      slice_q <= '0;
      acc_q   <= '0;
      zer_q   <= 1'b0;
      err_q   <= 1'b0;
      fail_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      slice_q <= slice_d;
      acc_q   <= acc_d;
      zer_q   <= zer_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      ones_q  <= ones_d;
    end
  end

  // Block data needs no reset: every block is fully rewritten before it is counted.
  always_ff @(posedge clk_i) begin
    if (word_we) block_q[int'(word_q)*OtpWidth +: OtpWidth] <= hw.hw_data_i;
    else if (shift_en) block_q <= block_q >> BitsPerCycle;
  end

  assign hw.hw_ready_o = ready;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign zeroized_o    = zer_q;
  assign err_o         = err_q;
  assign fail_idx_o    = fail_q;
  assign ones_cnt_o    = ones_q;

endmodule

// File: doc/otp_ctrl_zeroize_chk.md
Name: otp_ctrl_zeroize_chk

Overview:
- Downstream consumer of OTP macro read data during the OCP Lock zeroization flow.
- Accepts native 16-bit OTP words, assembles them into 64-bit scramble blocks and popcounts each block serially.
- Reports whether every block in a range meets the zeroization bound (at least 58 of 64 bits set).
- Sits between the OTP macro response channel and the DAI zeroize command sequencer.

Parameters:
- OtpWidth, 16, native OTP word width in bits.
- BlockWidth, 64, scramble block width; must be a multiple of OtpWidth.
- ValidBound, 58, minimum number of set bits for a block to count as zeroized.
- BitsPerCycle, 8, bits popcounted per cycle; must divide BlockWidth.
- CntWidth, 8, width of the block-count and block-index fields.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- start_i  in  1  start check of num_blocks_i blocks; sampled only in IDLE.
- num_blocks_i  in  CntWidth  number of 64-bit blocks to check; latched on start.
- busy_o  out  1  high from the cycle after an accepted start until DONE is left.
- hw_valid_i  in  1  OTP read word valid.
- hw_ready_o  out  1  word accepted when valid and ready are both high.
- hw_data_i  in  OtpWidth  OTP read word.
- hw_err_i  in  3  otp_err_e code accompanying the word.
- done_o  out  1  single-cycle completion pulse.
- zeroized_o  out  1  all blocks passed; held until the next accepted start.
- err_o  out  1  aborted on a macro or access error, or on an invalid count; held.
- fail_idx_o  out  CntWidth  index of the first failing block; held.
- ones_cnt_o  out  7  set-bit count of the last fully counted block (0..64); held.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. A reset mid-operation discards any partial block and counter state on that clock edge.
- FSM states: IDLE, COLLECT, COUNT, DONE.
- IDLE:
  - start_i=1 with num_blocks_i≠0: latch the count, clear zeroized_o, err_o, fail_idx_o and ones_cnt_o, then go to COLLECT.
  - start_i=1 with num_blocks_i=0: go to DONE with err_o=1 and zeroized_o=0.
- COLLECT:
  - hw_ready_o=1 in this state only.
  - Each accepted word fills the next slot: the first word goes to bits [15:0], the fourth to [63:48].
  - After the 4th word, go to COUNT with the bit counter cleared.
  - Error handling per accepted word:
    - hw_err_i in {NoError, MacroEccCorrError, MacroEccUncorrError}: data is used as-is. ECC errors are expected on zeroized words.
    - Any other code: go to DONE immediately with err_o=1, zeroized_o=0, fail_idx_o = current block index.
- COUNT:
  - Each cycle, add the popcount of BitsPerCycle bits, LSB slice first; a full block takes BlockWidth/BitsPerCycle = 8 cycles.
  - Accumulator is 7 bits and cannot overflow (max 64).
  - After the last slice, ones_cnt_o takes the total and the block is compared.
  - Total ≥ ValidBound: pass. If more blocks remain, increment the index and return to COLLECT; otherwise go to DONE with zeroized_o=1.
  - Total < ValidBound: go to DONE with zeroized_o=0 and fail_idx_o = index. This is an early exit; the remaining blocks are not requested.
- DONE:
  - Lasts exactly one cycle with done_o=1 and busy_o=1, then returns to IDLE.
  - zeroized_o, err_o and fail_idx_o hold until the next accepted start.
- start_i while busy is ignored.
- hw_valid_i outside COLLECT is ignored; no word is consumed.
- Latency with no backpressure, start accepted at cycle N (the cycle in which start_i is sampled in IDLE):
  - words accepted at N+1..N+4;
  - COUNT at N+5..N+12;
  - done_o at N+13 for a single block.
  - Each additional passing block adds 12 cycles.
  - Gaps in hw_valid_i extend COLLECT cycle for cycle.
- Block index wraps with no special handling; num_blocks_i max is 2^CntWidth−1.

Test Plan:
- Two all-ones blocks (8 words of 16'hFFFF), no gaps, start at cycle 0 -> done_o at cycle 25, zeroized_o=1, ones_cnt_o=64, err_o=0.
- One block with exactly 6 zero bits (words FFC0, FFFF, FFFF, FFFF) -> ones_cnt_o=58, zeroized_o=1.
- Three blocks where block 1 has 7 zero bits (first word FF80) -> zeroized_o=0, fail_idx_o=1, ones_cnt_o=57; only 8 words consumed; no hw_ready_o afterwards.
- All-ones block with hw_err_i=MacroEccUncorrError on every word -> zeroized_o=1, err_o=0.
- Block 0 second word with hw_err_i=MacroError -> done_o on the next cycle, err_o=1, zeroized_o=0, fail_idx_o=0.
- Control and flow corner cases:
  - start_i with num_blocks_i=0 -> done_o at cycle 1, err_o=1.
  - rst_ni low during COUNT -> all outputs 0 and IDLE on the next edge; a fresh start then completes normally.
  - hw_valid_i toggling every other cycle -> same result, with latency extended by the number of idle cycles.
